// File: rtl/mux_21_arb.sv
// Two-source round-robin burst arbiter steering a 2:1 data mux onto one valid/ready channel.
// A grant is held for up to MAX_BURST beats, or until the source marks its last beat or withdraws.
module mux_21_arb #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_i,
  input  logic [1:0]    last_i,
  input  logic [DW-1:0] data_0_i,
  input  logic [DW-1:0] data_1_i,
  output logic [1:0]    gnt_o,
  output logic          sel_o,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        state_r;
  logic          prio_r;
  logic [CW-1:0] beat_cnt_r;
  logic          sel_r;

  logic cur_s;
  logic in_grant_s;
  logic own_req_s;
  logic oth_req_s;
  logic own_last_s;
  logic xfer_s;
  logic burst_end_s;
  logic idle_pick_s;

  // Grant decode: which source owns the channel and whether this cycle closes its burst.
  always_comb begin
    in_grant_s = 1'b0;
    cur_s      = 1'b0;
    case (state_r)
      G0: begin
        in_grant_s = 1'b1;
        cur_s      = 1'b0;
      end
      G1: begin
        in_grant_s = 1'b1;
        cur_s      = 1'b1;
      end
      default: begin
        in_grant_s = 1'b0;
        cur_s      = 1'b0;
      end
    endcase
    own_req_s   = req_i[cur_s];
    oth_req_s   = req_i[~cur_s];
    own_last_s  = last_i[cur_s];
    out_valid   = in_grant_s & own_req_s;
    xfer_s      = out_valid & out_ready;
    if (xfer_s) begin
      gnt_o = cur_s ? 2'b10 : 2'b01;
    end else begin
      gnt_o = 2'b00;
    end
    // A withdrawn request closes the burst without a transfer.
    burst_end_s = in_grant_s &
                  (~own_req_s | (xfer_s & (own_last_s | (beat_cnt_r == CNT_LAST))));
    if (req_i == 2'b11) begin
      idle_pick_s = prio_r;
    end else begin
      idle_pick_s = req_i[1];
    end
  end

  assign sel_o    = sel_r;
  assign out_data = sel_r ? data_1_i : data_0_i;

  // Arbitration FSM with priority pointer, beat counter and registered mux select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      prio_r     <= 1'b0;
      beat_cnt_r <= CNT_ZERO;
      sel_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_i != 2'b00) begin
            state_r    <= idle_pick_s ? G1 : G0;
            sel_r      <= idle_pick_s;
            beat_cnt_r <= CNT_ZERO;
          end else begin
            state_r <= IDLE;
          end
        end
        G0, G1: begin
          if (burst_end_s) begin
            prio_r     <= ~cur_s;
            beat_cnt_r <= CNT_ZERO;
            if (oth_req_s) begin
              state_r <= cur_s ? G0 : G1;
              sel_r   <= ~cur_s;
            end else begin
              state_r <= IDLE;
            end
          end else if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_ONE;
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          beat_cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_21_arb.sv
// Directed bench for mux_21_arb: reset, single-source burst, round-robin alternation,
// back-pressure hold, withdrawal hand-over and mid-burst reset.
module tb_mux_21_arb;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_i;
  logic [1:0]    last_i;
  logic [DW-1:0] data_0_i;
  logic [DW-1:0] data_1_i;
  logic [1:0]    gnt_o;
  logic          sel_o;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_21_arb #(.DW(DW), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .last_i    (last_i),
    .data_0_i  (data_0_i),
    .data_1_i  (data_1_i),
    .gnt_o     (gnt_o),
    .sel_o     (sel_o),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] g, input logic s);
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, "_gnt"},   {30'd0, gnt_o},     {30'd0, g});
    chk({tag, "_sel"},   {31'd0, sel_o},     {31'd0, s});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic       exp_sel;
    logic [7:0] exp_d;
    logic [7:0] seq [3];
    seq[0] = 8'h11;
    seq[1] = 8'h22;
    seq[2] = 8'h33;

    // 1: reset with both requesting
    rst_n     = 1'b1;
    req_i     = 2'b11;
    last_i    = 2'b00;
    data_0_i  = 8'h00;
    data_1_i  = 8'h00;
    out_ready = 1'b0;
    #1 rst_n  = 1'b0;
    settle();
    chk_out("rst_async", 1'b0, 2'b00, 1'b0);
    tick();
    tick();
    chk_out("rst_hold", 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    settle();
    chk_out("idle_after_rst", 1'b0, 2'b00, 1'b0);
    tick();
    chk_out("g0_entry", 1'b1, 2'b00, 1'b0);

    // 2: source 0 alone, three beats, last on the third
    req_i     = 2'b01;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_0_i = seq[i];
      data_1_i = 8'hEE;
      last_i   = (i == 2) ? 2'b01 : 2'b00;
      settle();
      chk_out("src0_beat", 1'b1, 2'b01, 1'b0);
      chk("src0_data", {24'd0, out_data}, {24'd0, seq[i]});
      tick();
    end
    req_i  = 2'b00;
    last_i = 2'b00;
    settle();
    chk_out("src0_idle", 1'b0, 2'b00, 1'b0);
    tick();
    chk_out("src0_idle2", 1'b0, 2'b00, 1'b0);

    // 3: both requesting from a fresh reset; 4 beats each, no gap
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req_i     = 2'b11;
    last_i    = 2'b00;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      exp_sel  = ((i / 4) % 2) == 1;
      data_0_i = 8'hA0 + 8'(i);
      data_1_i = 8'hB0 + 8'(i);
      exp_d    = exp_sel ? (8'hB0 + 8'(i)) : (8'hA0 + 8'(i));
      settle();
      chk_out("rr_beat", 1'b1, exp_sel ? 2'b10 : 2'b01, exp_sel);
      chk("rr_data", {24'd0, out_data}, {24'd0, exp_d});
      tick();
    end

    // 4: in G1, one beat, then 5 stalled cycles, then the remaining 3 beats
    data_0_i = 8'h5A;
    data_1_i = 8'hC3;
    settle();
    chk_out("g1_first", 1'b1, 2'b10, 1'b1);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk_out("stall", 1'b1, 2'b00, 1'b1);
      chk("stall_data", {24'd0, out_data}, 32'h0000_00C3);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_out("resume", 1'b1, 2'b10, 1'b1);
      tick();
    end
    settle();
    chk_out("handover_g0", 1'b1, 2'b01, 1'b0);
    tick();

    // 5: withdrawals
    req_i = 2'b00;
    settle();
    chk_out("wd_g0_none", 1'b0, 2'b00, 1'b0);
    tick();
    req_i = 2'b11;
    settle();
    chk_out("wd_idle", 1'b0, 2'b00, 1'b0);
    tick();
    chk_out("prio1_g1", 1'b1, 2'b10, 1'b1);
    tick();
    req_i = 2'b01;
    settle();
    chk_out("wd_g1_drop", 1'b0, 2'b00, 1'b1);
    tick();
    chk_out("wd_to_g0", 1'b1, 2'b01, 1'b0);
    tick();
    req_i = 2'b00;
    tick();
    req_i = 2'b11;
    settle();
    chk_out("wd_idle2", 1'b0, 2'b00, 1'b0);
    tick();
    chk_out("prio1_again", 1'b1, 2'b10, 1'b1);
    tick();

    // 6: reset on beat 2 of a G1 burst, then arbitration restarts at source 0
    settle();
    chk_out("pre_rst_beat2", 1'b1, 2'b10, 1'b1);
    rst_n = 1'b0;
    settle();
    chk_out("mid_rst", 1'b0, 2'b00, 1'b0);
    tick();
    rst_n = 1'b1;
    settle();
    chk_out("post_rst_idle", 1'b0, 2'b00, 1'b0);
    tick();
    chk_out("post_rst_g0", 1'b1, 2'b01, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
